// File: rtl/ps2_matrix_scanner.sv
// PS/2 set-2 key events -> 8x8 keyboard matrix with active-low row scan and modifier flags.
// Define PS2_MATRIX_HOTRESET_EN to add the F11 hot-reset pulse output (reset_req).
module ps2_matrix_scanner (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  addr,
  output logic [7:0]  kb_cols,
  output logic [2:0]  modif
`ifdef PS2_MATRIX_HOTRESET_EN
  ,
  output logic        reset_req
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_e;

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] md;
  } map_ent_t;

  localparam logic [1:0] MOD_NONE  = 2'd0;
  localparam logic [1:0] MOD_SHIFT = 2'd1;
  localparam logic [1:0] MOD_CTRL  = 2'd2;
  localparam logic [1:0] MOD_GRAPH = 2'd3;

  // Key index is {extended, code}; modifier keys carry valid=0 so they never reach the matrix.
  function automatic map_ent_t map_lookup(input logic [8:0] key);
    map_ent_t e;
    e = '0;
    case (key)
      9'h029:  e = '{1'b1, 3'd0, 3'd0, MOD_NONE};   // space
      9'h076:  e = '{1'b1, 3'd0, 3'd2, MOD_NONE};   // esc
      9'h00D:  e = '{1'b1, 3'd0, 3'd3, MOD_NONE};   // tab
      9'h066:  e = '{1'b1, 3'd0, 3'd5, MOD_NONE};   // backspace
      9'h05A:  e = '{1'b1, 3'd0, 3'd6, MOD_NONE};   // enter
      9'h01C:  e = '{1'b1, 3'd5, 3'd1, MOD_NONE};   // A
      9'h032:  e = '{1'b1, 3'd5, 3'd2, MOD_NONE};   // B
      9'h021:  e = '{1'b1, 3'd5, 3'd3, MOD_NONE};   // C
      9'h16B:  e = '{1'b1, 3'd7, 3'd0, MOD_NONE};   // left
      9'h172:  e = '{1'b1, 3'd7, 3'd1, MOD_NONE};   // down
      9'h175:  e = '{1'b1, 3'd7, 3'd2, MOD_NONE};   // up
      9'h174:  e = '{1'b1, 3'd7, 3'd3, MOD_NONE};   // right
      9'h012,
      9'h059:  e = '{1'b0, 3'd0, 3'd0, MOD_SHIFT};
      9'h014,
      9'h114:  e = '{1'b0, 3'd0, 3'd0, MOD_CTRL};
      9'h011,
      9'h111:  e = '{1'b0, 3'd0, 3'd0, MOD_GRAPH};
      default: e = '0;
    endcase
    return e;
  endfunction

  logic            tog_q;
  key_evt_t        fifo_q [2];
  logic [1:0]      wr_ptr_q, rd_ptr_q;
  key_evt_t        work_q;
  map_ent_t        map_q;
  state_e          state_q;
  logic [7:0][7:0] matrix_q;
  logic            ctrl_q, graph_q, shl_q, shr_q;
  logic            ctrl_d, graph_d, shl_d, shr_d;
  logic [7:0]      kb_cols_q;
  logic [2:0]      modif_q;
  logic [7:0]      col_hit;

  logic evt, fifo_empty, fifo_full, push;
  assign evt        = ps2_key[10] ^ tog_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[0] == rd_ptr_q[0]) && (wr_ptr_q[1] != rd_ptr_q[1]);
  // Fullness is judged before this cycle's pop, so an event meeting a full FIFO is dropped.
  assign push       = evt && !fifo_full;

  // NOTE: storage with valid-tracking pointers needs no reset; only the pointers are cleared.
  always_ff @(posedge clk_sys) begin
    if (push) fifo_q[wr_ptr_q[0]] <= '{ps2_key[9], ps2_key[8], ps2_key[7:0]};
  end

  // NOTE: every variable assigned in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    ctrl_d  = ctrl_q;
    graph_d = graph_q;
    shl_d   = shl_q;
    shr_d   = shr_q;
    if (state_q == UPDATE) begin
      case (map_q.md)
        MOD_SHIFT: if (work_q.code == 8'h59) shr_d = work_q.pressed;
                   else                      shl_d = work_q.pressed;
        MOD_CTRL:  ctrl_d  = work_q.pressed;
        MOD_GRAPH: graph_d = work_q.pressed;
        default:   ;
      endcase
    end
  end

  always_comb begin
    col_hit = '0;
    for (int r = 0; r < 8; r++) begin
      if (!addr[r]) col_hit = col_hit | matrix_q[r];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      tog_q     <= ps2_key[10];
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      work_q    <= '0;
      map_q     <= '0;
      state_q   <= IDLE;
      matrix_q  <= '0;
      ctrl_q    <= 1'b0;
      graph_q   <= 1'b0;
      shl_q     <= 1'b0;
      shr_q     <= 1'b0;
      kb_cols_q <= 8'hFF;
      modif_q   <= '0;
    end else begin
      tog_q     <= ps2_key[10];
      ctrl_q    <= ctrl_d;
      graph_q   <= graph_d;
      shl_q     <= shl_d;
      shr_q     <= shr_d;
      modif_q   <= {ctrl_d, graph_d, shl_d | shr_d};
      kb_cols_q <= ~col_hit;
      if (push) wr_ptr_q <= wr_ptr_q + 2'd1;
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            work_q   <= fifo_q[rd_ptr_q[0]];
            rd_ptr_q <= rd_ptr_q + 2'd1;
            state_q  <= LOOKUP;
          end
        end
        LOOKUP: begin
          map_q   <= map_lookup({work_q.ext, work_q.code});
          state_q <= UPDATE;
        end
        UPDATE: begin
          if (map_q.valid) matrix_q[map_q.row][map_q.col] <= work_q.pressed;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign kb_cols = kb_cols_q;
  assign modif   = modif_q;

`ifdef PS2_MATRIX_HOTRESET_EN
  // F11 fires once per physical press; auto-repeat presses are ignored until a release re-arms it.
  logic f11_down_q, reset_req_q;
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      f11_down_q  <= 1'b0;
      reset_req_q <= 1'b0;
    end else begin
      reset_req_q <= 1'b0;
      if (state_q == UPDATE && !work_q.ext && work_q.code == 8'h78) begin
        reset_req_q <= work_q.pressed && !f11_down_q;
        f11_down_q  <= work_q.pressed;
      end
    end
  end
  assign reset_req = reset_req_q;
`endif

endmodule

// File: tb/tb_ps2_matrix_scanner.sv
// Directed bench for ps2_matrix_scanner: vector table plus hand sequences for latency, FIFO drop and reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_ps2_matrix_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [7:0]  addr;
  logic [7:0]  kb_cols;
  logic [2:0]  modif;
`ifdef PS2_MATRIX_HOTRESET_EN
  logic        reset_req;
`endif

  int checks   = 0;
  int failures = 0;

  always #15.625 clk = ~clk;

  ps2_matrix_scanner dut (
    .clk_sys (clk),
    .reset   (reset),
    .ps2_key (ps2_key),
    .addr    (addr),
    .kb_cols (kb_cols),
    .modif   (modif)
`ifdef PS2_MATRIX_HOTRESET_EN
    ,
    .reset_req (reset_req)
`endif
  );

  typedef struct packed {
    logic       pressed;
    logic       ext;
    logic [7:0] code;
    logic [7:0] addr;
    logic [7:0] exp_cols;
    logic [2:0] exp_mod;
  } vec_t;

  vec_t vecs [18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flips the toggle bit so the event is sampled on the next rising edge.
  task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

`ifdef PS2_MATRIX_HOTRESET_EN
  int  pulses  = 0;
  int  bad_len = 0;
  int  run_len = 0;
  logic mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      if (reset_req) run_len++;
      else begin
        if (run_len > 0) begin
          pulses++;
          if (run_len != 1) bad_len++;
        end
        run_len = 0;
      end
    end
  end
`endif

  initial begin
    // Stimulus table applied from a cleared matrix; expectations accumulate vector to vector.
    vecs[0]  = '{1'b1, 1'b0, 8'h29, 8'hFE, 8'hFE, 3'b000};
    vecs[1]  = '{1'b1, 1'b0, 8'h5A, 8'hFE, 8'hBE, 3'b000};
    vecs[2]  = '{1'b1, 1'b0, 8'h29, 8'h00, 8'hBE, 3'b000};
    vecs[3]  = '{1'b1, 1'b1, 8'h75, 8'h7F, 8'hFB, 3'b000};
    vecs[4]  = '{1'b0, 1'b0, 8'h29, 8'h7E, 8'hBB, 3'b000};
    vecs[5]  = '{1'b0, 1'b0, 8'h29, 8'h7E, 8'hBB, 3'b000};
    vecs[6]  = '{1'b1, 1'b0, 8'h12, 8'hFF, 8'hFF, 3'b001};
    vecs[7]  = '{1'b1, 1'b0, 8'h59, 8'hFE, 8'hBF, 3'b001};
    vecs[8]  = '{1'b0, 1'b0, 8'h12, 8'h00, 8'hBB, 3'b001};
    vecs[9]  = '{1'b0, 1'b0, 8'h59, 8'hFF, 8'hFF, 3'b000};
    vecs[10] = '{1'b1, 1'b0, 8'h14, 8'h7F, 8'hFB, 3'b100};
    vecs[11] = '{1'b1, 1'b1, 8'h11, 8'h7F, 8'hFB, 3'b110};
    vecs[12] = '{1'b0, 1'b1, 8'h14, 8'h7F, 8'hFB, 3'b010};
    vecs[13] = '{1'b0, 1'b0, 8'h11, 8'h7F, 8'hFB, 3'b000};
    vecs[14] = '{1'b1, 1'b0, 8'h75, 8'h00, 8'hBB, 3'b000};
    vecs[15] = '{1'b1, 1'b0, 8'h78, 8'h00, 8'hBB, 3'b000};
    vecs[16] = '{1'b0, 1'b0, 8'h78, 8'h00, 8'hBB, 3'b000};
    vecs[17] = '{1'b0, 1'b0, 8'h5A, 8'h00, 8'hFB, 3'b000};

    // Reset with toggle=1 and a pressed space pending: no event must follow reset.
    reset   = 1'b1;
    ps2_key = {1'b1, 1'b1, 1'b0, 8'h29};
    addr    = 8'h00;
    cycles(3);
    check("reset_cols", kb_cols, 8'hFF);
    check("reset_modif", modif, 3'b000);
`ifdef PS2_MATRIX_HOTRESET_EN
    check("reset_req_idle", reset_req, 1'b0);
`endif
    reset = 1'b0;
    cycles(8);
    check("no_spurious_event", kb_cols, 8'hFF);

    // Press A at edge T: still released before T+4, visible after T+4.
    addr = 8'hDF;
    send_key(1'b1, 1'b0, 8'h1C);
    cycles(4);
    check("latency_before_t4", kb_cols, 8'hFF);
    cycles(1);
    check("latency_at_t4", kb_cols, 8'hFD);
    send_key(1'b0, 1'b0, 8'h1C);
    cycles(6);
    check("release_a", kb_cols, 8'hFF);

    // Back-to-back events: the second arrives in the same cycle as the first is popped.
    addr = 8'hFE;
    send_key(1'b1, 1'b0, 8'h29);
    cycles(1);
    send_key(1'b1, 1'b0, 8'h5A);
    cycles(10);
    check("push_pop_fe", kb_cols, 8'hBE);
    addr = 8'h00;
    cycles(2);
    check("push_pop_00", kb_cols, 8'hBE);
    send_key(1'b0, 1'b0, 8'h29);
    cycles(1);
    send_key(1'b0, 1'b0, 8'h5A);
    cycles(10);
    check("push_pop_release", kb_cols, 8'hFF);

    // FIFO overflow: enter press occupies the FSM, then three consecutive toggles
    // (space press, space release, space press) fill the FIFO so the third is dropped.
    addr = 8'hFE;
    send_key(1'b1, 1'b0, 8'h5A);
    cycles(2);
    send_key(1'b1, 1'b0, 8'h29);
    cycles(1);
    send_key(1'b0, 1'b0, 8'h29);
    cycles(1);
    send_key(1'b1, 1'b0, 8'h29);
    cycles(4);
    check("fifo_first_applied", kb_cols, 8'hBE);
    cycles(3);
    check("fifo_second_applied", kb_cols, 8'hBF);
    cycles(20);
    check("fifo_third_dropped", kb_cols, 8'hBF);
    send_key(1'b0, 1'b0, 8'h5A);
    cycles(6);
    check("fifo_cleanup", kb_cols, 8'hFF);

    // Reset while up-arrow is in LOOKUP and a space press is queued behind it.
    addr = 8'h00;
    send_key(1'b1, 1'b1, 8'h75);
    cycles(1);
    send_key(1'b1, 1'b0, 8'h29);
    cycles(1);
    reset = 1'b1;
    cycles(2);
    check("midop_reset_cols", kb_cols, 8'hFF);
    reset = 1'b0;
    cycles(10);
    check("midop_abandon_all", kb_cols, 8'hFF);
    addr = 8'h7F;
    cycles(2);
    check("midop_abandon_up", kb_cols, 8'hFF);

    for (int i = 0; i < 18; i++) begin
      addr = vecs[i].addr;
      send_key(vecs[i].pressed, vecs[i].ext, vecs[i].code);
      cycles(6);
      check($sformatf("vec%0d_cols", i), kb_cols, vecs[i].exp_cols);
      check($sformatf("vec%0d_modif", i), modif, vecs[i].exp_mod);
    end
    send_key(1'b0, 1'b1, 8'h75);
    cycles(6);
    check("final_all_up", kb_cols, 8'hFF);

`ifdef PS2_MATRIX_HOTRESET_EN
    // F11 press, auto-repeat press, release, press: two single-cycle pulses.
    mon_en = 1'b1;
    send_key(1'b1, 1'b0, 8'h78);
    cycles(8);
    send_key(1'b1, 1'b0, 8'h78);
    cycles(8);
    send_key(1'b0, 1'b0, 8'h78);
    cycles(8);
    send_key(1'b1, 1'b0, 8'h78);
    cycles(8);
    mon_en = 1'b0;
    check("hotreset_pulses", pulses, 2);
    check("hotreset_bad_len", bad_len, 0);
    check("hotreset_cols", kb_cols, 8'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
